// File: rtl/heading_arbiter_if.sv
// heading_arbiter_if
//   Bundles the two operator stations' request/confirm/data lines and the
//   arbiter's grant, handshake-pulse and P/Q write-path outputs.
//   master : station side (drives req/cfm/data, observes everything else)
//   slave  : arbiter side (observes req/cfm/data, drives everything else)
//   Signals:
//     req0/req1   station request keys (level)
//     cfm0/cfm1   station confirm keys (level)
//     data0/data1 station bytes; bit7 = destination (0=P, 1=Q), bits6:0 = payload
//     gnt0/gnt1   station owns the datapath
//     ack0/ack1   one-cycle pulse, write committed
//     nak0/nak1   one-cycle pulse, transaction aborted
//     en_P/en_Q   single-cycle write enables to the P/Q register
//     dout        payload to the P/Q register data input
//     state       current FSM state code
interface heading_arbiter_if;
  logic       req0;
  logic       cfm0;
  logic [7:0] data0;
  logic       req1;
  logic       cfm1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       ack0;
  logic       ack1;
  logic       nak0;
  logic       nak1;
  logic       en_P;
  logic       en_Q;
  logic [6:0] dout;
  logic [2:0] state;

  modport master (
    output req0, cfm0, data0, req1, cfm1, data1,
    input  gnt0, gnt1, ack0, ack1, nak0, nak1, en_P, en_Q, dout, state
  );

  modport slave (
    input  req0, cfm0, data0, req1, cfm1, data1,
    output gnt0, gnt1, ack0, ack1, nak0, nak1, en_P, en_Q, dout, state
  );
endinterface

// File: rtl/heading_arbiter.sv
// heading_arbiter
//   Shares the heading P/Q register write path between two operator stations.
//   Round-robin grant, byte latched at grant, waits for the owner's confirm,
//   then issues a one-cycle P or Q write enable with ack, or a nak on
//   abort/timeout. The grant is held until the owner releases its request key
//   so a held key cannot re-trigger.
//   Ports:
//     clock  system clock, posedge
//     reset  synchronous active-high reset
//     bus    heading_arbiter_if.slave (station keys/data in, grants/pulses/write path out)
//   Parameter:
//     TIMEOUT  cycles spent waiting for confirm before aborting (1..255)
module heading_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic              clock,
  input logic              reset,
  heading_arbiter_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_CFM = 3'd1;
  localparam logic [2:0] COMMIT   = 3'd2;
  localparam logic [2:0] ABORT    = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  // Timer value on the edge where the wait has lasted TIMEOUT cycles.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_reg, last_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] timer_reg, timer_next;

  logic [1:0] req_vec;
  logic [1:0] cfm_vec;
  logic       req_own;
  logic       cfm_own;
  logic       grant_valid;
  logic       grant_ch;
  logic       active;

  assign req_vec = {bus.req1, bus.req0};
  assign cfm_vec = {bus.cfm1, bus.cfm0};
  assign req_own = req_vec[owner_reg];
  assign cfm_own = cfm_vec[owner_reg];

  // A tie goes to the channel that was not served last; a lone request
  // simply wins (req_vec[1] is 1 only when channel 1 is the requester).
  assign grant_valid = |req_vec;
  assign grant_ch    = (req_vec == 2'b11) ? ~last_reg : req_vec[1];

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next = grant_ch;
          hold_next  = grant_ch ? bus.data1 : bus.data0;
          timer_next = 8'd0;
          state_next = WAIT_CFM;
        end
      end
      WAIT_CFM: begin
        // Confirm beats a simultaneous key release.
        if (cfm_own) begin
          state_next = COMMIT;
        end else if (!req_own) begin
          state_next = ABORT;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = ABORT;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      COMMIT:  state_next = RELEASE;
      ABORT:   state_next = RELEASE;
      RELEASE: begin
        if (!req_own) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      hold_reg  <= 8'd0;
      timer_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      timer_reg <= timer_next;
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free
  // and all read zero straight after reset.
  assign active = (state_reg == WAIT_CFM) || (state_reg == COMMIT) ||
                  (state_reg == ABORT)    || (state_reg == RELEASE);

  logic [1:0] gnt_vec;
  logic [1:0] ack_vec;
  logic [1:0] nak_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign gnt_vec[gi] = active && (owner_reg == 1'(gi));
    assign ack_vec[gi] = (state_reg == COMMIT) && (owner_reg == 1'(gi));
    assign nak_vec[gi] = (state_reg == ABORT)  && (owner_reg == 1'(gi));
  end

  assign bus.gnt0  = gnt_vec[0];
  assign bus.gnt1  = gnt_vec[1];
  assign bus.ack0  = ack_vec[0];
  assign bus.ack1  = ack_vec[1];
  assign bus.nak0  = nak_vec[0];
  assign bus.nak1  = nak_vec[1];
  assign bus.en_P  = (state_reg == COMMIT) && !hold_reg[7];
  assign bus.en_Q  = (state_reg == COMMIT) &&  hold_reg[7];
  assign bus.dout  = hold_reg[6:0];
  assign bus.state = state_reg;

endmodule

// File: doc/heading_arbiter.md
Name: heading_arbiter

Overview:
- Shares the heading P/Q register write path between two operator stations (channel 0, channel 1).
- Each station has its own request/confirm keys and 8-bit data.
- Grants one station at a time in round-robin order and latches its byte, then waits for that station's confirm.
- On confirm, issues a single-cycle write enable to the P or Q register, then acknowledges (ack) or rejects (nak) the transaction.

Parameters:
TIMEOUT, 15, clock cycles WAIT_CFM waits for confirm before aborting (legal range 1..255)

Ports:
clock  in  1  system clock, posedge
reset  in  1  synchronous, active-high reset
req0  in  1  channel 0 request key, level
cfm0  in  1  channel 0 confirm key, level
data0  in  8  channel 0 data; bit7 = destination (0=P, 1=Q), bits6:0 = payload
req1  in  1  channel 1 request key
cfm1  in  1  channel 1 confirm key
data1  in  8  channel 1 data, same format as data0
gnt0  out  1  channel 0 owns the datapath
gnt1  out  1  channel 1 owns the datapath
ack0  out  1  one-cycle pulse: channel 0 write committed
ack1  out  1  one-cycle pulse: channel 1 write committed
nak0  out  1  one-cycle pulse: channel 0 transaction aborted
nak1  out  1  one-cycle pulse: channel 1 transaction aborted
en_P  out  1  write enable to P register
en_Q  out  1  write enable to Q register
dout  out  7  payload to the P/Q register data input
state  out  3  current FSM state, for test visibility

Behaviour:
- State encoding: IDLE=0, WAIT_CFM=1, COMMIT=2, ABORT=3, RELEASE=4. Codes 5-7 are unreachable and return to IDLE.
- Internal registers:
  - owner (1 bit)
  - last (1 bit, round-robin pointer)
  - hold (8 bits)
  - timer (8 bits)
- Reset (sync, any state) sets:
  - state=IDLE, owner=0, last=1 (so channel 0 wins the first tie), hold=0, timer=0.
  - All outputs 0, dout=0.
  - Reset mid-transaction drops it with no en, ack or nak.
- IDLE, on a clock edge:
  - One req high: grant that channel.
  - Both high: grant channel !last.
  - On grant: owner<=ch, hold<=data_ch, timer<=0, state<=WAIT_CFM.
  - No req: stay in IDLE.
- WAIT_CFM (gnt_owner=1), evaluated on each edge in priority order:
  - cfm_owner=1 -> COMMIT.
  - else req_owner=0 -> ABORT.
  - else timer==TIMEOUT-1 -> ABORT.
  - else timer<=timer+1.
  - The non-owner's cfm/req are ignored. Changes on data_owner after the grant are ignored, because the byte is captured at grant.
- COMMIT (exactly one cycle):
  - en_P=~hold[7], en_Q=hold[7], ack_owner=1.
  - Next state RELEASE.
  - Exactly one of en_P/en_Q is high, never both.
- ABORT (exactly one cycle): nak_owner=1, no enables, next state RELEASE.
- RELEASE:
  - gnt_owner stays high until req_owner is sampled low.
  - Then last<=owner, state<=IDLE, and gnt drops.
  - This prevents a held key from re-triggering.
- Output decode:
  - gnt/en/ack/nak are decoded from the registered state and owner.
  - gnt_owner is high in WAIT_CFM, COMMIT, ABORT and RELEASE; both gnts are low in IDLE; gnt0 and gnt1 are never high together.
  - dout=hold[6:0] continuously.
- Latency:
  - req sampled at edge k -> gnt high after edge k.
  - cfm sampled at edge m -> en/ack high for the cycle after edge m.
  - The P/Q register captures dout at edge m+1.
- Timeout: with WAIT_CFM entered at edge k and no confirm, ABORT is entered at edge k+TIMEOUT.
- Simultaneous events:
  - cfm and req release on the same edge -> COMMIT wins.
  - A request from the other channel during any non-IDLE state waits; it is granted on the first IDLE edge.
- Fairness: after a grant to channel c, a pending request on channel !c is served before c is served again.

Test Plan:
- Reset, then req0=1, data0=8'h25, cfm0=1 two cycles later. Required:
  - gnt0 after edge 1.
  - en_P=1, en_Q=0, dout=7'h25, ack0=1 for exactly one cycle.
  - gnt0 drops one cycle after req0 falls.
- req1=1, data1=8'hC3, then cfm1. Required: en_Q=1, dout=7'h43, ack1 pulse; gnt0 and nak1 stay 0.
- req0 and req1 both rise on the same edge after reset. Required:
  - Channel 0 is granted first, and its transaction completes.
  - Channel 1 is granted on the first IDLE edge after ch0 releases.
  - On the next tie, with ch1 last, channel 0 wins.
- req0=1 held, no cfm0, TIMEOUT=15. Required:
  - ABORT is entered 15 edges after WAIT_CFM entry.
  - nak0 pulses for one cycle, with no en_P or en_Q.
  - gnt0 is held until req0 falls.
- Grant ch0 with data0=8'h11, then change data0 to 8'h7F before cfm0. Required: dout=7'h11 at commit.
- Assert reset during WAIT_CFM, then separately during COMMIT. Required: state=0 and all outputs 0 on the next cycle, with no ack or nak pulse after the reset edge.
